// File: rtl/tcdm_rr_slave_arbiter_if.sv
// TCDM bus bundle between the requesting masters and the shared slave port.
// The "slave" modport is the arbiter's view (it serves the masters and
// drives the downstream slave); "master" is the environment's view.
interface tcdm_rr_slave_arbiter_if #(
    parameter int unsigned NR_MASTER_PORTS = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = 4
);
    // Master side
    logic [NR_MASTER_PORTS-1:0]                 m_req_i;
    logic [NR_MASTER_PORTS-1:0][ADDR_WIDTH-1:0] m_add_i;
    logic [NR_MASTER_PORTS-1:0]                 m_wen_i;
    logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0] m_wdata_i;
    logic [NR_MASTER_PORTS-1:0][BE_WIDTH-1:0]   m_be_i;
    logic [NR_MASTER_PORTS-1:0]                 m_gnt_o;
    logic [NR_MASTER_PORTS-1:0]                 m_r_valid_o;
    logic [DATA_WIDTH-1:0]                      m_r_rdata_o;
    logic                                       m_r_opc_o;
    // Slave side
    logic                                       s_req_o;
    logic [ADDR_WIDTH-1:0]                      s_add_o;
    logic                                       s_wen_o;
    logic [DATA_WIDTH-1:0]                      s_wdata_o;
    logic [BE_WIDTH-1:0]                        s_be_o;
    logic                                       s_gnt_i;
    logic                                       s_r_valid_i;
    logic [DATA_WIDTH-1:0]                      s_r_rdata_i;
    logic                                       s_r_opc_i;

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        output s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
    );

    modport master (
        output m_req_i, m_add_i, m_wen_i, m_wdata_i, m_be_i,
        output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
        input  s_req_o, s_add_o, s_wen_o, s_wdata_o, s_be_o
    );
endinterface

// File: rtl/tcdm_rr_slave_arbiter.sv
// Round-robin arbiter sharing one TCDM slave port between several masters.
// Requests are forwarded combinationally, a stalled request is locked until
// granted, the 1-cycle response is routed back to the handshake winner,
// protocol violations raise a sticky error and handshakes are counted.
module tcdm_rr_slave_arbiter #(
    parameter int unsigned NR_MASTER_PORTS = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = 4,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    tcdm_rr_slave_arbiter_if.slave bus,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o
);

    localparam int unsigned IDX_W = (NR_MASTER_PORTS > 1) ? $clog2(NR_MASTER_PORTS) : 1;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_LAST = idx_t'(NR_MASTER_PORTS - 1);

    idx_t                 rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    idx_t                 lock_idx_q, lock_idx_d;
    logic                 pend_q, pend_d;
    idx_t                 pend_idx_q, pend_idx_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
    logic                 first_q, first_d;

    idx_t        rr_idx;
    idx_t        winner;
    logic        s_req;
    logic        hs;
    logic        rr_found;
    int unsigned scan_k;

    // Round-robin scan: first requester at or above rr_ptr_q, wrapping to 0.
    always_comb begin
        rr_idx   = rr_ptr_q;
        rr_found = 1'b0;
        scan_k   = 0;
        for (int unsigned i = 0; i < NR_MASTER_PORTS; i++) begin
            scan_k = {{(32-IDX_W){1'b0}}, rr_ptr_q} + i;
            if (scan_k >= NR_MASTER_PORTS) begin
                scan_k = scan_k - NR_MASTER_PORTS;
            end
            if (!rr_found && bus.m_req_i[scan_k[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = scan_k[IDX_W-1:0];
            end
        end
    end

    // Request path: locked master keeps the slave port, otherwise the RR winner.
    always_comb begin
        winner        = lock_q ? lock_idx_q : rr_idx;
        s_req         = lock_q ? bus.m_req_i[winner] : (|bus.m_req_i);
        // Grant is suppressed while reset is asserted.
        hs            = s_req & bus.s_gnt_i & ~rst_i;
        bus.s_req_o   = s_req;
        bus.s_add_o   = bus.m_add_i[winner];
        bus.s_wen_o   = bus.m_wen_i[winner];
        bus.s_wdata_o = bus.m_wdata_i[winner];
        bus.s_be_o    = bus.m_be_i[winner];
        bus.m_gnt_o   = '0;
        if (hs) begin
            bus.m_gnt_o[winner] = 1'b1;
        end
    end

    // Response path: route valid to the master that won the previous handshake.
    always_comb begin
        bus.m_r_valid_o = '0;
        if (pend_q && bus.s_r_valid_i) begin
            bus.m_r_valid_o[pend_idx_q] = 1'b1;
        end
        bus.m_r_rdata_o = bus.s_r_rdata_i;
        bus.m_r_opc_o   = bus.s_r_opc_i;
    end

    // Next-state: pointer, lock, pending response, counter and error tracking.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        pend_d     = hs;
        pend_idx_d = hs ? winner : pend_idx_q;
        err_d      = err_q;
        xfer_cnt_d = xfer_cnt_q;
        first_d    = 1'b0;

        if (hs) begin
            rr_ptr_d   = (winner == IDX_LAST) ? '0 : winner + idx_t'(1);
            lock_d     = 1'b0;
            xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
        end else if (s_req && !bus.s_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = winner;
        end

        // Locked master withdrew its request before being granted.
        if (lock_q && !bus.m_req_i[lock_idx_q]) begin
            err_d  = 1'b1;
            lock_d = 1'b0;
        end
        // Unexpected response; tolerated in the first cycle after reset.
        if (bus.s_r_valid_i && !pend_q && !first_q) begin
            err_d = 1'b1;
        end
        // Expected response did not arrive.
        if (pend_q && !bus.s_r_valid_i) begin
            err_d = 1'b1;
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= '0;
            first_q    <= 1'b1;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
            first_q    <= first_d;
        end
    end

    assign err_o      = err_q;
    assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: doc/tcdm_rr_slave_arbiter.md
Name: tcdm_rr_slave_arbiter

Overview:
- Shares one TCDM slave port between NR_MASTER_PORTS requesters using round-robin arbitration.
- Routes the fixed-latency (1 cycle) response back to the master that won the handshake.
- Sits in front of a single-ported L2/peripheral target behind the SoC interconnect crossbar.
- Holds the slave-side request stable while it is pending, flags protocol errors, and counts completed transfers.

Parameters:
- NR_MASTER_PORTS, 4, number of requesters (>=1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, wdata/rdata width.
- BE_WIDTH, 4, byte-enable width.
- CNT_WIDTH, 16, transfer counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- m_req_i  in  NR_MASTER_PORTS  per-master request.
- m_add_i  in  NR_MASTER_PORTS x ADDR_WIDTH  per-master address.
- m_wen_i  in  NR_MASTER_PORTS  per-master write enable (1 = read, 0 = write; TCDM polarity).
- m_wdata_i  in  NR_MASTER_PORTS x DATA_WIDTH  per-master write data.
- m_be_i  in  NR_MASTER_PORTS x BE_WIDTH  per-master byte enables.
- m_gnt_o  out  NR_MASTER_PORTS  per-master grant.
- m_r_valid_o  out  NR_MASTER_PORTS  per-master response valid.
- m_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters.
- m_r_opc_o  out  1  response error bit, broadcast to all masters.
- s_req_o  out  1  slave request.
- s_add_o  out  ADDR_WIDTH  slave address.
- s_wen_o  out  1  slave write enable.
- s_wdata_o  out  DATA_WIDTH  slave write data.
- s_be_o  out  BE_WIDTH  slave byte enables.
- s_gnt_i  in  1  slave grant.
- s_r_valid_i  in  1  slave response valid.
- s_r_rdata_i  in  DATA_WIDTH  slave response data.
- s_r_opc_i  in  1  slave response error bit.
- err_o  out  1  sticky protocol error flag.
- xfer_cnt_o  out  CNT_WIDTH  count of completed handshakes.

Behaviour:
- Index width is IDX_W = max(1, $clog2(NR_MASTER_PORTS)).
- Registers and their reset values (all reset while rst_i=1):
  - rr_ptr_q = 0.
  - lock_q = 0, lock_idx_q = 0.
  - pend_q = 0, pend_idx_q = 0.
  - err_o = 0, xfer_cnt_o = 0.
  - first_q = 1.
- Outputs during and directly after reset: m_gnt_o = 0, m_r_valid_o = 0, s_req_o = |m_req_i.
- Winner selection (combinational):
  - If lock_q = 1: winner = lock_idx_q.
  - Otherwise: winner = first index with m_req_i set, scanning from rr_ptr_q upward and wrapping at NR_MASTER_PORTS-1 -> 0.
- Request path (combinational, zero latency):
  - s_req_o = m_req_i[winner] when lock_q=1, else |m_req_i.
  - s_add_o, s_wen_o, s_wdata_o and s_be_o are muxed from the winner.
  - When no request is present, slave payload outputs are don't-care.
- Grant: m_gnt_o[winner] = s_req_o & s_gnt_i. All other m_gnt_o bits are 0, so at most one bit is set per cycle.
- Handshake (hs) = s_req_o & s_gnt_i. On hs:
  - rr_ptr_q <= (winner+1) mod NR_MASTER_PORTS.
  - pend_q <= 1, pend_idx_q <= winner.
  - lock_q <= 0.
  - xfer_cnt_o <= xfer_cnt_o+1, wrapping at 2^CNT_WIDTH-1 -> 0.
- No handshake:
  - s_req_o=1 & s_gnt_i=0: lock_q <= 1, lock_idx_q <= winner. The slave sees a stable request until granted, and a later request from a higher-priority master does not displace it.
  - Otherwise: pend_q <= 0.
- If the locked master drops m_req_i (TCDM protocol violation): err_o <= 1, lock_q <= 0.
- Response path, with latency exactly 1 cycle after hs:
  - m_r_valid_o[pend_idx_q] = s_r_valid_i & pend_q.
  - m_r_rdata_o = s_r_rdata_i, m_r_opc_o = s_r_opc_i.
  - Writes also return r_valid (write response on).
- Protocol errors that set err_o <= 1:
  - s_r_valid_i=1 while pend_q=0: response is dropped.
  - pend_q=1 while s_r_valid_i=0: response is missing.
  - Exception: a spurious s_r_valid_i in the cycle with first_q=1 is ignored without error.
  - first_q <= 0 after the first clock edge following reset release.
- err_o is cleared only by reset.
- Back-to-back traffic: a handshake and the response of the previous handshake may occur in the same cycle, giving full throughput of 1 transfer/cycle.
- NR_MASTER_PORTS=1: pass-through; rr_ptr_q stays 0.
- Reset mid-transfer: pend_q and lock_q are cleared immediately. A slave response arriving in the first cycle after reset release is not forwarded.

Test Plan:
- Single request: m_req_i=4'b0100 with s_gnt_i=1 at cycle 0 -> m_gnt_o=4'b0100 in cycle 0; m_r_valid_o=4'b0100 in cycle 1 with rdata 0xDEADBEEF; xfer_cnt_o=1.
- Fairness: m_req_i=4'b1111 held, s_gnt_i=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each response routed to the matching master one cycle after its grant; xfer_cnt_o=8.
- Lock under backpressure: m_req_i=4'b0110, s_gnt_i=0 for 3 cycles, master 0 raises req in cycle 1, then s_gnt_i=1 -> s_add_o stays at master 1's address through all 3 stall cycles; grant goes to 1, then 2, then 0.
- Protocol errors:
  - s_r_valid_i=1 with no prior handshake (after the first post-reset cycle) -> m_r_valid_o=0 and err_o=1.
  - Separately, after reset, a handshake with no s_r_valid_i next cycle -> err_o=1.
- Reset mid-stall: lock_q set on master 3, rst_i pulsed asynchronously mid-cycle -> m_gnt_o=0 and err_o=0 immediately; after release with m_req_i=4'b1000, the next grant follows rr_ptr=0 scan and selects master 3.
- Counter wrap: CNT_WIDTH=4, 17 handshakes -> xfer_cnt_o=1.
